// File: rtl/pid_pkg.sv
// Definitions shared by the PID controller and its PWM output stage.
package pid_pkg;

    localparam int CTRL_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        DEAD,
        HI,
        LO
    } pwm_state_t;

endpackage

// File: rtl/pwm_driver_if.sv
// Control/status bundle between the PID stage (master) and the PWM output stage (slave).
interface pwm_driver_if;

    logic                          en;
    logic [pid_pkg::CTRL_W-1:0]    duty;
    logic                          pwm_hi;
    logic                          pwm_lo;
    logic                          period_start;
    logic [pid_pkg::CTRL_W-1:0]    duty_active;

    modport master (
        output en,
        output duty,
        input  pwm_hi,
        input  pwm_lo,
        input  period_start,
        input  duty_active
    );

    modport slave (
        input  en,
        input  duty,
        output pwm_hi,
        output pwm_lo,
        output period_start,
        output duty_active
    );

endinterface

// File: rtl/dead_time_gen.sv
// Turns the raw PWM demand into a complementary pair with a break-before-make gap.
module dead_time_gen
    import pid_pkg::*;
#(
    parameter int DEAD_TIME = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic raw,
    output logic pwm_hi,
    output logic pwm_lo
);

    localparam int              DT_W    = (DEAD_TIME > 0) ? $clog2(DEAD_TIME + 1) : 1;
    localparam logic [DT_W-1:0] DT_LOAD = DT_W'(DEAD_TIME);
    localparam logic [DT_W-1:0] DT_ONE  = DT_W'(1);

    pwm_state_t      state;
    logic            target;
    logic [DT_W-1:0] dt;
    logic            side_change;

    assign side_change = (state == IDLE) || (state == HI && !raw) || (state == LO && raw);

    // NOTE: outputs are assigned next to the state they belong to, with non-blocking
    // assignments, so both pins change on the same edge as the FSM and can never overlap.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            state  <= IDLE;
            target <= 1'b0;
            dt     <= '0;
            pwm_hi <= 1'b0;
            pwm_lo <= 1'b0;
        end else begin
            unique case (state)
                IDLE, HI, LO: begin
                    if (side_change) begin
                        if (DEAD_TIME == 0) begin
                            state  <= raw ? HI : LO;
                            pwm_hi <= raw;
                            pwm_lo <= !raw;
                        end else begin
                            state  <= DEAD;
                            target <= raw;
                            dt     <= DT_LOAD;
                            pwm_hi <= 1'b0;
                            pwm_lo <= 1'b0;
                        end
                    end
                end
                DEAD: begin
                    // A demand flip during the gap restarts it, which swallows short pulses.
                    if (raw != target) begin
                        target <= raw;
                        dt     <= DT_LOAD;
                    end else if (dt == DT_ONE) begin
                        state  <= target ? HI : LO;
                        pwm_hi <= target;
                        pwm_lo <= !target;
                    end else begin
                        dt <= dt - DT_ONE;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/pwm_driver.sv
// PWM output stage: prescaled period counter, double-buffered duty and period strobe,
// feeding a dead-time generator that drives the complementary pair.
module pwm_driver
    import pid_pkg::*;
#(
    parameter int PRESCALE  = 1,
    parameter int DEAD_TIME = 4
) (
    input logic          clk,
    input logic          rst,
    pwm_driver_if.slave  bus
);

    localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0]   presc;
    logic [CTRL_W-1:0] cnt;
    logic [CTRL_W-1:0] duty_active;
    logic              period_start;
    logic              run_q;
    logic              tick;
    logic              raw;
    logic              pwm_hi;
    logic              pwm_lo;

    assign tick = (presc == PS_LAST);
    assign raw  = (cnt < duty_active);

    // run_q marks the first enabled cycle, where the shadow duty is loaded and cnt restarts.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc        <= '0;
            cnt          <= '0;
            duty_active  <= '0;
            period_start <= 1'b0;
            run_q        <= 1'b0;
        end else if (!bus.en) begin
            presc        <= '0;
            cnt          <= '0;
            period_start <= 1'b0;
            run_q        <= 1'b0;
        end else if (!run_q) begin
            presc        <= '0;
            cnt          <= '0;
            duty_active  <= bus.duty;
            period_start <= 1'b1;
            run_q        <= 1'b1;
        end else begin
            period_start <= 1'b0;
            if (tick) begin
                presc <= '0;
                cnt   <= cnt + CTRL_W'(1);
                if (cnt == '1) begin
                    duty_active  <= bus.duty;
                    period_start <= 1'b1;
                end
            end else begin
                presc <= presc + PS_W'(1);
            end
        end
    end

    // The generator starts one cycle after enable so its first target sees the fresh shadow duty.
    dead_time_gen #(
        .DEAD_TIME (DEAD_TIME)
    ) u_dead_time (
        .clk    (clk),
        .rst    (rst),
        .en     (bus.en && run_q),
        .raw    (raw),
        .pwm_hi (pwm_hi),
        .pwm_lo (pwm_lo)
    );

    assign bus.pwm_hi       = pwm_hi;
    assign bus.pwm_lo       = pwm_lo;
    assign bus.period_start = period_start;
    assign bus.duty_active  = duty_active;

endmodule

// File: doc/pwm_driver.md
# pwm_driver

Output stage downstream of the PID controller: converts the 8-bit unsigned control word into a complementary PWM pair with programmable dead time. Emits a one-cycle `period_start` pulse that upstream logic uses as the PID sample strobe. The duty word is double-buffered so that a duty change never produces a glitch mid-period.

## Interface
- `PRESCALE`, default 1: clk cycles per PWM counter tick (≥1).
- `DEAD_TIME`, default 4: clk cycles both outputs are held low on every side change (0 = none).
- `clk` in 1: sole clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset; dominant over all other inputs.
- `en` in 1: run enable; level-sensitive.
- `duty` in 8: requested duty, unsigned, sampled only at a period boundary.
- `pwm_hi` out 1: high-side drive, registered.
- `pwm_lo` out 1: low-side drive, registered, complement of `pwm_hi` outside dead time.
- `period_start` out 1: one-cycle pulse on the first cycle of each period.
- `duty_active` out 8: shadow duty currently in use.

## Operation
- Reset: `pwm_hi`=0, `pwm_lo`=0, `period_start`=0, `duty_active`=0, prescaler=0, period counter `cnt`=0, FSM=IDLE.
- Prescaler counts 0..PRESCALE-1; `tick` is asserted when it equals PRESCALE-1. With PRESCALE=1, `tick` is asserted every cycle.
- `cnt` is 8 bits and increments on `tick`, wrapping 255→0. Period = 256·PRESCALE clk cycles.
- Shadow load: `duty_active` ← `duty` on the cycle `cnt` wraps to 0 and on the enable start. `period_start` is asserted in that same cycle. A `duty` change at any other time is ignored until the next wrap.
- Raw demand: `raw = (cnt < duty_active)`. Duty 0 gives 0%; duty 255 gives 255/256.
- Dead-time FSM states: IDLE, DEAD, HI, LO. A `target` register and a dead counter `dt` are kept alongside the state.
  - IDLE: both outputs 0. When `en` rises, go to DEAD with `target`=raw and `dt`=DEAD_TIME.
  - HI/LO: the matching output is 1. When raw differs from the current side, go to DEAD with `target`=raw and `dt`=DEAD_TIME; both outputs are 0 next cycle.
  - DEAD: both outputs 0 and `dt` decrements. If raw ≠ `target`, update `target` and reload `dt`=DEAD_TIME. When `dt` reaches 0, go to HI if `target`=1, otherwise LO.
  - With DEAD_TIME=0, DEAD is skipped and the FSM goes directly HI↔LO.
- Pulses shorter than DEAD_TIME are swallowed. `pwm_hi` and `pwm_lo` are never both 1 in any cycle.
- `en` low: on the next edge both outputs are 0, the prescaler and `cnt` clear, the FSM goes to IDLE, and `duty_active` is held.

## Timing
- If raw changes after edge k, the active output falls at edge k+1. The opposite output rises at edge k+1+DEAD_TIME.
- High-side on-time per period = duty·PRESCALE − DEAD_TIME cycles, floored at 0.
- `en` rising at edge k: `period_start`=1 and `cnt`=0 in the cycle after edge k; the first conducting output rises at edge k+1+DEAD_TIME.
- `period_start` asserts and `duty_active` updates on the same edge that `cnt` becomes 0.
- `rst` mid-period: the full reset state is applied at the next edge regardless of `en`.

## Structure
- Shared package `pid_pkg`:
  - FSM state enum (IDLE/DEAD/HI/LO).
  - `CTRL_W`=8 (control word width shared with the PID stage).
- Sub-module `dead_time_gen`: owns the FSM, `target` and `dt`. Inputs are `raw` and `en`; outputs are `pwm_hi` and `pwm_lo`.
- The top level holds the prescaler, `cnt`, the shadow register and `period_start`.

## Test plan
All scenarios use PRESCALE=1 and DEAD_TIME=4.
- Reset: `rst`=1 with `en`=1 and `duty`=200 for 10 cycles → all outputs 0 and `duty_active`=0. After release, `period_start` pulses on the first cycle.
- Steady state: `duty`=128, `en`=1 → `period_start` every 256 cycles; `pwm_hi` high 124 cycles and `pwm_lo` high 124 cycles per period; both low for 4 cycles at each edge; `pwm_hi`&`pwm_lo` never both 1.
- Mid-period update: `duty` changes 128→64 at `cnt`=10 → the current period keeps `duty_active`=128; the next period has `duty_active`=64 and `pwm_hi` high 60 cycles.
- Narrow pulse: `duty`=2 → `pwm_hi` stays 0; `pwm_lo` is low for 6 cycles starting at each `cnt`=0 and otherwise high. `duty`=0 → `pwm_lo` stays high after the initial 4-cycle dead time.
- Enable toggle: `en` dropped at `cnt`=50 → both outputs are 0 on the next cycle and no `period_start`. When `en` is re-raised, `period_start` pulses on the next cycle with `cnt`=0 and fresh `duty` loaded.
- `rst` asserted for one cycle at `cnt`=100 with `pwm_hi`=1 → both outputs 0 and `duty_active`=0 next cycle. With `en` held, the FSM restarts from IDLE.
